// File: rtl/rom_load_arbiter.sv
// rtl/rom_load_arbiter.sv - HPS ROM download and core read arbiter for a shared single-port RAM
// Downloads own the RAM while the core is held in reset; at run time core reads win over a 1-entry write buffer.
module rom_load_arbiter #(
   parameter logic [16:0] ROM_SIZE    = 17'h0C000,
   parameter int unsigned HOLD_CYCLES = 16
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic        core_rd,
   input  logic [15:0] core_addr,
   input  logic [7:0]  mem_q,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_din,
   output logic        mem_we,
   output logic [7:0]  core_dout,
   output logic        core_rvalid,
   output logic        core_reset,
   output logic [16:0] load_bytes,
   output logic        err_oor,
   output logic        err_ovf
);

   localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN} state_t;

   state_t      state, state_nxt;
   logic [7:0]  hold_cnt, hold_cnt_nxt;
   logic        buf_valid, buf_valid_nxt;
   logic [15:0] buf_addr, buf_addr_nxt;
   logic [7:0]  buf_data, buf_data_nxt;
   logic        rd_grant, rd_grant_nxt;
   logic [15:0] mem_addr_nxt;
   logic [7:0]  mem_din_nxt;
   logic        mem_we_nxt, rvalid_nxt, core_reset_nxt;
   logic [16:0] load_bytes_nxt;
   logic        err_oor_nxt, err_ovf_nxt;
   logic        drain;
   logic        addr_ok;

   assign addr_ok = (ioctl_addr < {8'd0, ROM_SIZE});

   // mem_q already lines up with the rvalid cycle, so the data path is gated rather than re-registered
   assign core_dout = core_rvalid ? mem_q : 8'd0;

   always_ff @(posedge CLK) begin
      if (RESET) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (ioctl_download) state_nxt = S_LOAD;
         S_LOAD: if (!ioctl_download) state_nxt = S_HOLD;
         S_HOLD: begin
            if (ioctl_download)        state_nxt = S_LOAD;
            else if (hold_cnt == 8'd0) state_nxt = S_RUN;
         end
         S_RUN:  if (ioctl_download) state_nxt = S_LOAD;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      mem_addr_nxt   = mem_addr;
      mem_din_nxt    = mem_din;
      mem_we_nxt     = 1'b0;
      core_reset_nxt = (state_nxt != S_RUN);
      rd_grant_nxt   = 1'b0;
      rvalid_nxt     = rd_grant && (state_nxt == S_RUN);
      hold_cnt_nxt   = hold_cnt;
      load_bytes_nxt = load_bytes;
      err_oor_nxt    = err_oor;
      err_ovf_nxt    = err_ovf;
      buf_valid_nxt  = buf_valid;
      buf_addr_nxt   = buf_addr;
      buf_data_nxt   = buf_data;
      drain          = 1'b0;
      if (state_nxt == S_LOAD && state != S_LOAD) load_bytes_nxt = 17'd0;
      case (state)
         S_LOAD: begin
            if (!ioctl_download) hold_cnt_nxt = HOLD_INIT;
            if (ioctl_wr) begin
               if (addr_ok) begin
                  mem_we_nxt   = 1'b1;
                  mem_addr_nxt = ioctl_addr[15:0];
                  mem_din_nxt  = ioctl_dout;
                  if (load_bytes != 17'h1FFFF) load_bytes_nxt = load_bytes + 17'd1;
               end else begin
                  err_oor_nxt = 1'b1;
               end
            end
         end
         S_HOLD: if (hold_cnt != 8'd0) hold_cnt_nxt = hold_cnt - 8'd1;
         S_RUN: begin
            if (core_rd) begin
               rd_grant_nxt = 1'b1;
               mem_addr_nxt = core_addr;
            end
            // a download request abandons any buffered run-time write
            if (!ioctl_download) begin
               drain = buf_valid && !core_rd;
               if (drain) begin
                  mem_we_nxt    = 1'b1;
                  mem_addr_nxt  = buf_addr;
                  mem_din_nxt   = buf_data;
                  buf_valid_nxt = 1'b0;
               end
               if (ioctl_wr) begin
                  if (!addr_ok) begin
                     err_oor_nxt = 1'b1;
                  end else if (buf_valid && !drain) begin
                     err_ovf_nxt = 1'b1;
                  end else begin
                     buf_valid_nxt = 1'b1;
                     buf_addr_nxt  = ioctl_addr[15:0];
                     buf_data_nxt  = ioctl_dout;
                  end
               end
            end else begin
               buf_valid_nxt = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         mem_addr    <= 16'd0;
         mem_din     <= 8'd0;
         mem_we      <= 1'b0;
         core_reset  <= 1'b1;
         core_rvalid <= 1'b0;
         rd_grant    <= 1'b0;
         hold_cnt    <= 8'd0;
         load_bytes  <= 17'd0;
         err_oor     <= 1'b0;
         err_ovf     <= 1'b0;
         buf_valid   <= 1'b0;
         buf_addr    <= 16'd0;
         buf_data    <= 8'd0;
      end else begin
         mem_addr    <= mem_addr_nxt;
         mem_din     <= mem_din_nxt;
         mem_we      <= mem_we_nxt;
         core_reset  <= core_reset_nxt;
         core_rvalid <= rvalid_nxt;
         rd_grant    <= rd_grant_nxt;
         hold_cnt    <= hold_cnt_nxt;
         load_bytes  <= load_bytes_nxt;
         err_oor     <= err_oor_nxt;
         err_ovf     <= err_ovf_nxt;
         buf_valid   <= buf_valid_nxt;
         buf_addr    <= buf_addr_nxt;
         buf_data    <= buf_data_nxt;
      end
   end

endmodule

// File: tb/tb_rom_load_arbiter.sv
// tb/tb_rom_load_arbiter.sv - directed and randomized bench for rom_load_arbiter against a golden memory image
module tb_rom_load_arbiter;

   localparam logic [24:0] ROM_LIMIT = 25'h0C000;
   localparam int          HOLD_LEN  = 16;

   logic        CLK;
   logic        RESET;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        core_rd;
   logic [15:0] core_addr;
   logic [7:0]  mem_q;
   logic [15:0] mem_addr;
   logic [7:0]  mem_din;
   logic        mem_we;
   logic [7:0]  core_dout;
   logic        core_rvalid;
   logic        core_reset;
   logic [16:0] load_bytes;
   logic        err_oor;
   logic        err_ovf;

   rom_load_arbiter dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .core_rd        (core_rd),
      .core_addr      (core_addr),
      .mem_q          (mem_q),
      .mem_addr       (mem_addr),
      .mem_din        (mem_din),
      .mem_we         (mem_we),
      .core_dout      (core_dout),
      .core_rvalid    (core_rvalid),
      .core_reset     (core_reset),
      .load_bytes     (load_bytes),
      .err_oor        (err_oor),
      .err_ovf        (err_ovf)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // shared single-port RAM with one cycle of read latency
   logic [7:0] ram [0:65535];
   always @(posedge CLK) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_q <= ram[mem_addr];
   end

   logic [7:0]  golden [0:65535];
   logic [15:0] wq [$];
   int          n_vec;
   int          n_err;
   int          exp_cnt;
   logic        exp_oor;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [15:0] rnd_addr();
      logic [9:0] hi;
      hi = ($urandom_range(0, 1) == 0) ? 10'h000 : 10'h2FF;
      return {hi, 6'($urandom_range(0, 63))};
   endfunction

   task automatic do_read(input logic [15:0] a);
      core_rd = 1'b1; core_addr = a;
      step();
      core_rd = 1'b0;
      chk("rd_addr", 32'(mem_addr), 32'(a));
      chk("rd_nowe", 32'(mem_we), 0);
      chk("rd_early", 32'(core_rvalid), 0);
      step();
      chk("rd_valid", 32'(core_rvalid), 1);
      chk("rd_data", 32'(core_dout), 32'(golden[a]));
   endtask

   task automatic run_write(input logic [15:0] a, input logic [7:0] d);
      ioctl_wr = 1'b1; ioctl_addr = 25'(a); ioctl_dout = d;
      step();
      ioctl_wr = 1'b0;
      chk("rw_buffered", 32'(mem_we), 0);
      step();
      chk("rw_we", 32'(mem_we), 1);
      chk("rw_addr", 32'(mem_addr), 32'(a));
      chk("rw_din", 32'(mem_din), 32'(d));
      golden[a] = d;
   endtask

   task automatic run_rd_wr(input logic [15:0] ra, input logic [15:0] wa, input logic [7:0] d);
      core_rd = 1'b1; core_addr = ra;
      ioctl_wr = 1'b1; ioctl_addr = 25'(wa); ioctl_dout = d;
      step();
      core_rd = 1'b0; ioctl_wr = 1'b0;
      chk("rdwr_addr", 32'(mem_addr), 32'(ra));
      chk("rdwr_nowe", 32'(mem_we), 0);
      step();
      chk("rdwr_valid", 32'(core_rvalid), 1);
      chk("rdwr_data", 32'(core_dout), 32'(golden[ra]));
      chk("rdwr_we", 32'(mem_we), 1);
      chk("rdwr_waddr", 32'(mem_addr), 32'(wa));
      chk("rdwr_din", 32'(mem_din), 32'(d));
      golden[wa] = d;
   endtask

   task automatic load_write(input logic [24:0] a, input logic [7:0] d, input logic last);
      logic [15:0] a16;
      a16 = a[15:0];
      ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
      if (last) ioctl_download = 1'b0;
      step();
      ioctl_wr = 1'b0;
      if (a < ROM_LIMIT) begin
         chk("ld_we", 32'(mem_we), 1);
         chk("ld_addr", 32'(mem_addr), 32'(a16));
         chk("ld_din", 32'(mem_din), 32'(d));
         golden[a16] = d;
         wq.push_back(a16);
         exp_cnt++;
      end else begin
         chk("ld_oor_nowe", 32'(mem_we), 0);
         exp_oor = 1'b1;
      end
      chk("ld_count", 32'(load_bytes), 32'(exp_cnt));
      chk("ld_err_oor", 32'(err_oor), 32'(exp_oor));
      chk("ld_no_rvalid", 32'(core_rvalid), 0);
   endtask

   task automatic wait_run(output int n);
      n = 0;
      while (core_reset === 1'b1 && n < 64) begin
         n++;
         step();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      logic [7:0]  d, d1, d2;
      logic [15:0] a;
      logic [24:0] la;
      logic [7:0]  dat3 [0:2];

      n_vec = 0; n_err = 0; exp_cnt = 0; exp_oor = 1'b0;
      for (int i = 0; i < 65536; i++) begin
         ram[i] = 8'd0;
         golden[i] = 8'd0;
      end
      RESET = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = 25'd0;
      ioctl_dout = 8'd0; core_rd = 1'b0; core_addr = 16'd0;
      step(); step();
      chk("rst_core_reset", 32'(core_reset), 1);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_rvalid", 32'(core_rvalid), 0);
      chk("rst_load_bytes", 32'(load_bytes), 0);
      chk("rst_err_oor", 32'(err_oor), 0);
      chk("rst_err_ovf", 32'(err_ovf), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_din", 32'(mem_din), 0);
      chk("rst_core_dout", 32'(core_dout), 0);
      RESET = 1'b0;

      // IDLE ignores writes and reads
      ioctl_wr = 1'b1; ioctl_addr = 25'h3; ioctl_dout = 8'h77; core_rd = 1'b1; core_addr = 16'h3;
      step();
      ioctl_wr = 1'b0; core_rd = 1'b0;
      chk("idle_nowe", 32'(mem_we), 0);
      step();
      chk("idle_no_rvalid", 32'(core_rvalid), 0);
      chk("idle_core_reset", 32'(core_reset), 1);

      // three-byte download then hold
      dat3[0] = 8'hA5; dat3[1] = 8'h5A; dat3[2] = 8'hFF;
      ioctl_download = 1'b1;
      step();
      for (int i = 0; i < 3; i++) load_write(25'(i), dat3[i], 1'b0);
      chk("dl3_count", 32'(load_bytes), 3);
      ioctl_download = 1'b0;
      step();
      wait_run(n);
      chk("dl3_hold_len", 32'(n), 32'(HOLD_LEN));
      chk("dl3_run", 32'(core_reset), 0);

      do_read(16'h0001);
      do_read(16'h0000);
      do_read(16'h0002);

      // write held behind three back-to-back reads
      d = 8'($urandom);
      core_rd = 1'b1; core_addr = 16'h0002;
      ioctl_wr = 1'b1; ioctl_addr = 25'h4000; ioctl_dout = d;
      step();
      ioctl_wr = 1'b0;
      chk("hold_c2_nowe", 32'(mem_we), 0);
      chk("hold_c2_addr", 32'(mem_addr), 32'h0002);
      step();
      chk("hold_c3_nowe", 32'(mem_we), 0);
      chk("hold_c3_valid", 32'(core_rvalid), 1);
      chk("hold_c3_data", 32'(core_dout), 32'(golden[16'h0002]));
      step();
      chk("hold_c4_nowe", 32'(mem_we), 0);
      core_rd = 1'b0;
      step();
      chk("hold_drain_we", 32'(mem_we), 1);
      chk("hold_drain_addr", 32'(mem_addr), 32'h4000);
      chk("hold_drain_din", 32'(mem_din), 32'(d));
      golden[16'h4000] = d;
      step();
      chk("hold_single_we", 32'(mem_we), 0);
      do_read(16'h4000);

      // second write into a full, non-draining buffer is dropped
      d1 = 8'($urandom); d2 = ~d1;
      core_rd = 1'b1; core_addr = 16'h0000;
      ioctl_wr = 1'b1; ioctl_addr = 25'h4100; ioctl_dout = d1;
      step();
      chk("ovf_not_yet", 32'(err_ovf), 0);
      ioctl_addr = 25'h4200; ioctl_dout = d2;
      step();
      ioctl_wr = 1'b0;
      chk("ovf_flag", 32'(err_ovf), 1);
      chk("ovf_nowe", 32'(mem_we), 0);
      step();
      chk("ovf_nowe2", 32'(mem_we), 0);
      core_rd = 1'b0;
      step();
      chk("ovf_drain_we", 32'(mem_we), 1);
      chk("ovf_drain_addr", 32'(mem_addr), 32'h4100);
      chk("ovf_drain_din", 32'(mem_din), 32'(d1));
      golden[16'h4100] = d1;
      step();
      chk("ovf_no_second", 32'(mem_we), 0);
      chk("ovf_sticky", 32'(err_ovf), 1);
      do_read(16'h4100);
      do_read(16'h4200);

      // randomized run-time traffic
      for (int k = 0; k < 40; k++) begin
         a = rnd_addr();
         d = 8'($urandom);
         case ($urandom_range(0, 2))
            0:       do_read(a);
            1:       run_write(a, d);
            default: run_rd_wr(rnd_addr(), a, d);
         endcase
      end
      chk("run_no_oor", 32'(err_oor), 0);

      // randomized re-download with range boundaries, reads requested throughout
      ioctl_download = 1'b1;
      step();
      chk("redl_core_reset", 32'(core_reset), 1);
      chk("redl_count_clr", 32'(load_bytes), 0);
      exp_cnt = 0;
      wq.delete();
      core_rd = 1'b1; core_addr = 16'h0001;
      load_write(25'h0C000, 8'h11, 1'b0);
      load_write(25'h0BFFF, 8'($urandom), 1'b0);
      for (int k = 0; k < 20; k++) begin
         if ($urandom_range(0, 7) == 0) la = 25'($urandom_range(32'h0000C000, 32'h01FFFFFF));
         else                           la = 25'(rnd_addr());
         load_write(la, 8'($urandom), 1'b0);
         repeat ($urandom_range(0, 2)) begin
            step();
            chk("ld_gap_nowe", 32'(mem_we), 0);
         end
      end
      core_rd = 1'b0;
      load_write(25'h0020, 8'($urandom), 1'b1);
      wait_run(n);
      chk("redl_hold_len", 32'(n), 32'(HOLD_LEN));
      chk("redl_run", 32'(core_reset), 0);
      chk("redl_oor_sticky", 32'(err_oor), 1);
      foreach (wq[i]) do_read(wq[i]);

      // reset during HOLD with the counter at 5
      ioctl_download = 1'b1;
      step();
      exp_cnt = 0;
      load_write(25'h0010, 8'h3C, 1'b1);
      ioctl_wr = 1'b1; ioctl_addr = 25'h5; ioctl_dout = 8'h99;
      step();
      ioctl_wr = 1'b0;
      chk("hold_ignores_wr", 32'(mem_we), 0);
      repeat (9) step();
      chk("hold_core_reset", 32'(core_reset), 1);
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      exp_oor = 1'b0;
      chk("hrst_core_reset", 32'(core_reset), 1);
      chk("hrst_load_bytes", 32'(load_bytes), 0);
      chk("hrst_err_oor", 32'(err_oor), 0);
      chk("hrst_err_ovf", 32'(err_ovf), 0);
      chk("hrst_mem_we", 32'(mem_we), 0);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (core_reset === 1'b1) n++;
      end
      chk("hrst_stays_idle", 32'(n), 40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rom_load_arbiter.md
ROM_LOAD_ARBITER -- requirements
Module: rom_load_arbiter

Interface
REQ-001 SHALL have parameter ROM_SIZE, default 17'h0C000, meaning the count of valid byte addresses; addresses at or above it are out of range.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, meaning the number of cycles core reset is held after a download ends (legal range 1..255).
REQ-003 SHALL have ports:
  CLK            in   1   system clock; the only clock.
  RESET          in   1   reset; synchronous, active-high.
  ioctl_download in   1   HPS download window active.
  ioctl_wr       in   1   HPS byte write strobe, one cycle.
  ioctl_addr     in   25  HPS byte address.
  ioctl_dout     in   8   HPS write data.
  core_rd        in   1   core read request, one cycle.
  core_addr      in   16  core read address.
  mem_q          in   8   shared single-port RAM read data; 1-cycle latency from mem_addr.
  mem_addr       out  16  shared RAM address.
  mem_din        out  8   shared RAM write data.
  mem_we         out  1   shared RAM write enable.
  core_dout      out  8   read data to core.
  core_rvalid    out  1   core_dout valid.
  core_reset     out  1   reset to the game core.
  load_bytes     out  17  accepted bytes in the last or current download.
  err_oor        out  1   sticky: an out-of-range write was dropped.
  err_ovf        out  1   sticky: a run-time write was dropped on buffer overflow.

Function
REQ-004 SHALL implement FSM states IDLE, LOAD, HOLD, RUN.
REQ-005 IDLE: core_reset=1; when ioctl_download=1, SHALL go to LOAD next cycle.
REQ-006 LOAD: core_reset=1; load_bytes cleared on entry; each ioctl_wr with ioctl_addr<ROM_SIZE SHALL drive mem_addr=ioctl_addr[15:0], mem_din=ioctl_dout, mem_we=1 on the next cycle, i.e. with 1-cycle registered latency.
REQ-007 LOAD: each accepted write SHALL increment load_bytes, saturating at 17'h1FFFF; a write with ioctl_addr>=ROM_SIZE SHALL be dropped, not counted, and SHALL set err_oor.
REQ-008 LOAD: when ioctl_download=0, SHALL go to HOLD with the hold counter loaded to HOLD_CYCLES-1; an ioctl_wr coincident with the falling download is still processed as a LOAD write.
REQ-009 HOLD: core_reset=1; counter decrements each cycle; at 0 SHALL go to RUN, so core_reset is high for exactly HOLD_CYCLES cycles after the download ends. If ioctl_download rises in HOLD, SHALL return to LOAD.
REQ-010 RUN: core_reset=0; if ioctl_download=1, SHALL go to LOAD, with core_reset=1 from the next cycle.
REQ-011 RUN reads: a core_rd SHALL always be granted, with mem_addr=core_addr and mem_we=0 the next cycle; core_rvalid SHALL pulse 2 cycles after core_rd, with core_dout=mem_q.
REQ-012 Outside RUN, core_rd SHALL be ignored and core_rvalid SHALL stay 0.
REQ-013 RUN writes: an ioctl_wr with ioctl_download=0 in RUN (NVRAM/hiscore path) SHALL enter a 1-entry write buffer if the address is in range; otherwise err_oor is set.
REQ-014 The buffer SHALL drain on the first cycle with no core_rd, issuing mem_we=1 the following cycle. A pending core read SHALL always win over a buffered write.
REQ-015 If ioctl_wr arrives while the buffer is full and not draining that cycle, the new write SHALL be dropped and err_ovf set. Writes arriving on the drain cycle are accepted.
REQ-016 ioctl_wr in IDLE or HOLD SHALL be ignored with no flag.
REQ-017 mem_addr, mem_din, mem_we, core_reset, core_rvalid SHALL be registered outputs; mem_we SHALL never be asserted in the same cycle as a granted read.
REQ-018 Leaving RUN with the buffer full SHALL discard the buffered write.

Reset
REQ-019 RESET=1 SHALL, on the next CLK edge, force IDLE, core_reset=1, and clear mem_we, core_rvalid, the buffer, hold counter, load_bytes, err_oor and err_ovf. This applies mid-LOAD or mid-HOLD as well.
REQ-020 Reset values: mem_addr=0, mem_din=0, core_dout=0.

Verification
REQ-021 Download of 3 bytes to addrs 0,1,2 (data A5,5A,FF), then ioctl_download low -> mem_we pulses 1 cycle after each wr with matching addr/data; load_bytes=3; core_reset high for 16 cycles, then 0.
REQ-022 In LOAD, write to addr 0x0C000 -> no mem_we, load_bytes unchanged, err_oor=1 until RESET.
REQ-023 In RUN, core_rd addr 0x0001 -> mem_addr=0x0001 at +1, core_rvalid=1 with core_dout=mem_q at +2.
REQ-024 In RUN, ioctl_wr addr 0x4000 while core_rd is high for 3 consecutive cycles -> write held; mem_we=1 at addr 0x4000 exactly one cycle after the first cycle with core_rd=0.
REQ-025 In RUN, two ioctl_wr while core_rd is continuously high -> first write retained and later written, second dropped, err_ovf=1.
REQ-026 RESET pulsed during HOLD with counter at 5 -> IDLE, core_reset stays 1, load_bytes=0; RUN not entered without a new download.
